m_mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RISC-V pipe. It consumes the M pipeline register outputs and performs the load or store on a data-memory port that uses a req/gnt/rvalid handshake.
- It produces the load result (m_valM) for the W pipeline register and the forwarding logic.
- It raises a stall to the hazard unit while a memory transaction is outstanding.
- Memory latency is variable, so the stage is sequenced by a small FSM.

---
 rtl/m_mem_stage.sv | 140 ++++++++++++++
 tb/tb_m_mem_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_mem_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid data port,
// stalls the pipe while a transaction is outstanding, and registers the load result.
module m_mem_stage #(
    parameter int XLEN = 64,
    parameter int AW   = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [6:0]      M_opcode_i,
    input  logic [2:0]      M_func3_i,
    input  logic [XLEN-1:0] M_valE_i,
    input  logic [XLEN-1:0] M_valB_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [AW-1:0]   dmem_addr_o,
    output logic [7:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] m_valM_o,
    output logic            m_stall_o,
    output logic            m_misalign_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_R = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   valm_q, valm_d;
    logic [2:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;

    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              misalign;
    logic [2:0]        off;
    logic [7:0]        be_base;
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   load_ext;

    always_comb begin
        is_load  = (M_opcode_i == OP_LOAD) && (M_func3_i != 3'b111);
        is_store = (M_opcode_i == OP_STORE) && !M_func3_i[2];
        is_mem   = is_load || is_store;
        off      = M_valE_i[2:0];
        misalign = 1'b0;
        be_base  = 8'h01;
        case (M_func3_i[1:0])
            2'd0: begin misalign = 1'b0;       be_base = 8'h01; end
            2'd1: begin misalign = off[0];     be_base = 8'h03; end
            2'd2: begin misalign = |off[1:0];  be_base = 8'h0F; end
            default: begin misalign = |off;    be_base = 8'hFF; end
        endcase
    end

    // Address, lanes and data are driven straight from M; M is frozen by the stall until grant.
    assign dmem_addr_o  = {M_valE_i[AW-1:3], 3'b000};
    assign dmem_be_o    = be_base << off;
    assign dmem_wdata_o = M_valB_i << {off, 3'b000};
    assign dmem_we_o    = is_store;
    assign m_valM_o     = valm_q;

    // Extraction uses the offset/size/sign captured at grant, not the live M inputs.
    always_comb begin
        rd_shift = dmem_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_ext = {{(XLEN-8){sgn_q & rd_shift[7]}},   rd_shift[7:0]};
            2'd1:    load_ext = {{(XLEN-16){sgn_q & rd_shift[15]}}, rd_shift[15:0]};
            2'd2:    load_ext = {{(XLEN-32){sgn_q & rd_shift[31]}}, rd_shift[31:0]};
            default: load_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        valm_d       = valm_q;
        off_d        = off_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        dmem_req_o   = 1'b0;
        m_stall_o    = 1'b0;
        m_misalign_o = 1'b0;
        case (state_q)
            IDLE: begin
                valm_d = '0;
                if (is_mem && !misalign) begin
                    dmem_req_o = 1'b1;
                    m_stall_o  = 1'b1;
                    if (dmem_gnt_i) begin
                        off_d   = off;
                        size_d  = M_func3_i[1:0];
                        sgn_d   = !M_func3_i[2];
                        state_d = is_load ? WAIT_R : DONE;
                    end
                end else begin
                    m_misalign_o = is_mem && misalign;
                end
            end
            WAIT_R: begin
                m_stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    valm_d  = load_ext;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            valm_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valm_q  <= valm_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
        end
    end

endmodule

// File: tb/tb_m_mem_stage.sv
// Randomized bench for m_mem_stage: a transaction-level model predicts every
// output cycle by cycle; one negedge process compares DUT against it.
module tb_m_mem_stage;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [6:0]  M_opcode_i;
    logic [2:0]  M_func3_i;
    logic [63:0] M_valE_i;
    logic [63:0] M_valB_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [7:0]  dmem_be_o;
    logic [63:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic [63:0] m_valM_o;
    logic        m_stall_o;
    logic        m_misalign_o;

    always #5 clk_i = ~clk_i;

    m_mem_stage #(.XLEN(64), .AW(64)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .M_opcode_i    (M_opcode_i),
        .M_func3_i     (M_func3_i),
        .M_valE_i      (M_valE_i),
        .M_valB_i      (M_valB_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .m_valM_o      (m_valM_o),
        .m_stall_o     (m_stall_o),
        .m_misalign_o  (m_misalign_o)
    );

    int asserts = 0;
    int fails   = 0;

    logic        chk_en = 1'b0;
    logic        e_req, e_stall, e_mis, e_we;
    logic [63:0] e_addr, e_wdata, e_valm;
    logic [7:0]  e_be;
    logic        lit_v_en = 1'b0;
    logic [63:0] lit_v;
    logic        lit_b_en = 1'b0;
    logic [7:0]  lit_b;
    logic [63:0] prev_valm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("req",      64'(dmem_req_o),   64'(e_req));
            chk("stall",    64'(m_stall_o),    64'(e_stall));
            chk("misalign", 64'(m_misalign_o), 64'(e_mis));
            chk("valM",     m_valM_o,          e_valm);
            if (e_req) begin
                chk("addr",  dmem_addr_o,      e_addr);
                chk("be",    64'(dmem_be_o),   64'(e_be));
                chk("we",    64'(dmem_we_o),   64'(e_we));
                chk("wdata", dmem_wdata_o,     e_wdata);
            end
            if (lit_v_en) chk("valM_literal", m_valM_o, lit_v);
            if (lit_b_en) chk("be_literal", 64'(dmem_be_o), 64'(lit_b));
        end
    end

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] rd);
        int          n = nbytes(f3);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(int'(off)+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] valb, input int gd, input int rdl,
                       input logic [63:0] rdata, input logic lve, input logic [63:0] lv,
                       input logic lbe, input logic [7:0] lb);
        logic        ld, st, mis;
        logic [63:0] res;
        int          n, mask;
        ld   = (op == OP_LOAD) && (f3 != 3'b111);
        st   = (op == OP_STORE) && !f3[2];
        n    = nbytes(f3);
        mis  = (ld || st) && ((int'(addr[2:0]) % n) != 0);
        mask = (1 << n) - 1;
        M_opcode_i = op; M_func3_i = f3; M_valE_i = addr; M_valB_i = valb;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = {$urandom, $urandom};
        e_addr  = {addr[63:3], 3'b000};
        e_be    = 8'(mask << addr[2:0]);
        e_wdata = valb << (8 * int'(addr[2:0]));
        e_we    = st;
        e_mis   = mis;
        e_valm  = prev_valm;
        if (!(ld || st) || mis) begin
            e_req = 1'b0; e_stall = 1'b0;
            step();
            prev_valm = '0;
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            e_req = 1'b1; e_stall = 1'b1;
            dmem_gnt_i = (k == gd);
            lit_b_en = lbe; lit_b = lb;
            step();
            e_valm = '0;
        end
        dmem_gnt_i = 1'b0; lit_b_en = 1'b0;
        res = '0;
        if (ld) begin
            for (int k = 0; k <= rdl; k++) begin
                e_req = 1'b0; e_stall = 1'b1;
                dmem_gnt_i    = 1'($urandom);
                dmem_rvalid_i = (k == rdl);
                dmem_rdata_i  = (k == rdl) ? rdata : {$urandom, $urandom};
                step();
            end
            res = m_load(f3, addr[2:0], rdata);
        end
        e_req = 1'b0; e_stall = 1'b0; e_valm = res;
        lit_v_en = lve; lit_v = lv;
        dmem_gnt_i    = 1'($urandom);
        dmem_rvalid_i = 1'($urandom);
        dmem_rdata_i  = {$urandom, $urandom};
        step();
        lit_v_en = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        prev_valm = res;
    endtask

    initial begin
        logic [63:0] a, rdv;
        logic [2:0]  f3;
        logic [6:0]  op;
        int          kind, n;

        rst_i = 1'b0;
        M_opcode_i = '0; M_func3_i = '0; M_valE_i = '0; M_valB_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0; e_we = 1'b0;
        e_addr = '0; e_wdata = '0; e_valm = '0; e_be = '0; lit_v = '0; lit_b = '0;
        prev_valm = '0;
        chk_en = 1'b1;
        step(); step();
        rst_i = 1'b1;
        step();

        run(OP_LOAD, 3'b011, 64'h100, 64'h0, 0, 0, 64'h1122334455667788,
            1'b1, 64'h1122334455667788, 1'b1, 8'hFF);
        run(OP_LOAD, 3'b000, 64'h107, 64'h0, 0, 0, 64'h80AA_BBCC_DDEE_FF01,
            1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 8'h80);
        run(OP_LOAD, 3'b100, 64'h107, 64'h0, 0, 0, 64'h80AA_BBCC_DDEE_FF01,
            1'b1, 64'h0000_0000_0000_0080, 1'b1, 8'h80);
        run(OP_STORE, 3'b001, 64'h102, 64'hABCD, 3, 0, 64'h0,
            1'b1, 64'h0, 1'b1, 8'h0C);
        run(OP_LOAD, 3'b010, 64'h101, 64'h0, 0, 0, 64'h0, 1'b0, 64'h0, 1'b0, 8'h0);
        for (int i = 0; i < 3; i++)
            run(OP_ALU, 3'b000, 64'h100, 64'h5, 0, 0, 64'h0, 1'b0, 64'h0, 1'b0, 8'h0);

        // Reset dropped into WAIT_R; a late rvalid afterwards must be ignored.
        M_opcode_i = OP_LOAD; M_func3_i = 3'b011; M_valE_i = 64'h200; M_valB_i = '0;
        e_addr = 64'h200; e_be = 8'hFF; e_we = 1'b0; e_wdata = '0; e_mis = 1'b0;
        e_req = 1'b1; e_stall = 1'b1; e_valm = prev_valm;
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0; e_req = 1'b0; e_stall = 1'b1; e_valm = '0;
        step();
        rst_i = 1'b0; M_opcode_i = OP_ALU; e_stall = 1'b0;
        step(); step();
        rst_i = 1'b1;
        step();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        dmem_rvalid_i = 1'b0;
        step();
        prev_valm = '0;

        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 9));
            a    = {$urandom, $urandom};
            rdv  = {$urandom, $urandom};
            if (kind < 5) begin
                op = OP_LOAD;  f3 = 3'($urandom_range(0, 6));
            end else if (kind < 9) begin
                op = OP_STORE; f3 = 3'($urandom_range(0, 3));
            end else begin
                op = 7'($urandom); f3 = 3'($urandom);
            end
            n = nbytes(f3);
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'(int'($urandom_range(0, 7)) / n * n);
            run(op, f3, a, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), rdv, 1'b0, 64'h0, 1'b0, 8'h0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
